// File: rtl/series_accumulator.sv
// -----------------------------------------------------------------------------
// series_accumulator
//
// Purpose:
//   Sums NUM_TERMS consecutive sign-magnitude product terms from the sine
//   datapath multiplier. When ALTERNATE_SIGN is set, the sign of every
//   odd-indexed term (1, 3, ...) is inverted, giving x - x^3/3! + x^5/5! ...
//   The magnitude saturates at full scale, and a sticky flag reports any
//   saturation. The finished sum is offered on an avail/get handshake.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   pre_avail  in   1      upstream term valid
//   pre_get    out  1      term accepted this cycle (depends on state only)
//   pre_data   in   FXD_N  sign-magnitude term (bit FXD_N-1 = sign)
//   post_avail out  1      result valid
//   post_get   in   1      downstream accepts the result
//   post_data  out  FXD_N  sign-magnitude sum, never negative zero
//   post_ovf   out  1      saturation occurred in this result
// -----------------------------------------------------------------------------
module series_accumulator #(
  parameter int FXD_Q          = 4,
  parameter int FXD_N          = 8,
  parameter int NUM_TERMS      = 4,
  parameter int ALTERNATE_SIGN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pre_avail,
  output logic             pre_get,
  input  logic [FXD_N-1:0] pre_data,
  output logic             post_avail,
  input  logic             post_get,
  output logic [FXD_N-1:0] post_data,
  output logic             post_ovf
);

  localparam int MAG_W = FXD_N - 1;
  localparam int CNT_W = 8;
  localparam logic [MAG_W-1:0] MAG_MAX  = '1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TERMS - 1);
  localparam logic             ALT_EN   = (ALTERNATE_SIGN != 0);

  // Parameter legality is checked at elaboration time.
  if (NUM_TERMS < 1 || NUM_TERMS > 255) begin : g_bad_num_terms
    $error("series_accumulator: NUM_TERMS must be in 1..255");
  end
  if (FXD_Q < 0 || FXD_Q > FXD_N - 1) begin : g_bad_fxd_q
    $error("series_accumulator: FXD_Q must be in 0..FXD_N-1");
  end

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             acc_sign_q, acc_sign_d;
  logic [MAG_W-1:0] acc_mag_q, acc_mag_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             term_sign;
  logic [MAG_W-1:0] term_mag;
  logic [MAG_W:0]   mag_sum;
  logic             sum_sign;
  logic [MAG_W-1:0] sum_mag;
  logic             sum_sat;
  logic             in_xfer;
  logic             out_xfer;

  // Gated by rst_n so no term can be claimed while reset is held, even
  // though the state register already reads ACCUM.
  assign pre_get    = rst_n && (state_q == ACCUM);
  assign post_avail = (state_q == DONE);
  assign post_data  = post_avail ? {acc_sign_q, acc_mag_q} : '0;
  assign post_ovf   = post_avail && ovf_q;

  assign in_xfer  = pre_get && pre_avail;
  assign out_xfer = post_avail && post_get;

  // Sign-magnitude adder. The accumulator never holds negative zero, and a
  // zero-magnitude term is forced to +0 before the sign comparison.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    term_mag  = pre_data[MAG_W-1:0];
    term_sign = (pre_data[FXD_N-1] ^ (ALT_EN & count_q[0])) & (term_mag != '0);
    mag_sum   = {1'b0, acc_mag_q} + {1'b0, term_mag};
    sum_sign  = 1'b0;
    sum_mag   = '0;
    sum_sat   = 1'b0;

    if (term_sign == acc_sign_q) begin
      sum_sign = acc_sign_q;
      if (mag_sum[MAG_W]) begin
        sum_mag = MAG_MAX;
        sum_sat = 1'b1;
      end else begin
        sum_mag = mag_sum[MAG_W-1:0];
      end
    end else if (acc_mag_q > term_mag) begin
      sum_sign = acc_sign_q;
      sum_mag  = acc_mag_q - term_mag;
    end else if (term_mag > acc_mag_q) begin
      sum_sign = term_sign;
      sum_mag  = term_mag - acc_mag_q;
    end

    if (sum_mag == '0) begin
      sum_sign = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    acc_sign_d = acc_sign_q;
    acc_mag_d  = acc_mag_q;
    count_d    = count_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      ACCUM: begin
        if (in_xfer) begin
          acc_sign_d = sum_sign;
          acc_mag_d  = sum_mag;
          ovf_d      = ovf_q | sum_sat;
          count_d    = count_q + 1'b1;
          if (count_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Upstream is ignored here; the result is held until taken.
        if (out_xfer) begin
          state_d    = ACCUM;
          acc_sign_d = 1'b0;
          acc_mag_d  = '0;
          count_d    = '0;
          ovf_d      = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state flops use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_sign_q <= 1'b0;
      acc_mag_q  <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_sign_q <= acc_sign_d;
      acc_mag_q  <= acc_mag_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_series_accumulator.sv
// -----------------------------------------------------------------------------
// tb_series_accumulator
//
// Two instances: index 0 sums plainly (ALTERNATE_SIGN=0), index 1 alternates
// term signs (ALTERNATE_SIGN=1). Directed series push their hand-computed
// {ovf, data} result into a per-instance queue; a monitor pops and compares
// whenever a result transfer is visible on the output handshake.
// -----------------------------------------------------------------------------
module tb_series_accumulator;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      pre_avail_a = '0;
  logic [1:0]      pre_get_a;
  logic [1:0][7:0] pre_data_a = '0;
  logic [1:0]      post_avail_a;
  logic [1:0]      post_get_a = '0;
  logic [1:0][7:0] post_data_a;
  logic [1:0]      post_ovf_a;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];

  always #5 clk = ~clk;

  series_accumulator #(.FXD_Q(4), .FXD_N(8), .NUM_TERMS(4), .ALTERNATE_SIGN(0)) u_plain (
    .clk        (clk),
    .rst_n      (rst_n),
    .pre_avail  (pre_avail_a[0]),
    .pre_get    (pre_get_a[0]),
    .pre_data   (pre_data_a[0]),
    .post_avail (post_avail_a[0]),
    .post_get   (post_get_a[0]),
    .post_data  (post_data_a[0]),
    .post_ovf   (post_ovf_a[0])
  );

  series_accumulator #(.FXD_Q(4), .FXD_N(8), .NUM_TERMS(4), .ALTERNATE_SIGN(1)) u_alt (
    .clk        (clk),
    .rst_n      (rst_n),
    .pre_avail  (pre_avail_a[1]),
    .pre_get    (pre_get_a[1]),
    .pre_data   (pre_data_a[1]),
    .post_avail (post_avail_a[1]),
    .post_get   (post_get_a[1]),
    .post_data  (post_data_a[1]),
    .post_ovf   (post_ovf_a[1])
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic ovf, input logic [7:0] data);
    if (d == 0) exp_q0.push_back({ovf, data});
    else        exp_q1.push_back({ovf, data});
  endtask

  task automatic pop_and_check(input int d);
    logic [8:0] e;
    int         n;
    n = (d == 0) ? exp_q0.size() : exp_q1.size();
    if (n == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_result_d%0d: got 0x%0h with no expected entry", d,
               {post_ovf_a[d], post_data_a[d]});
    end else begin
      e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("result_d%0d", d), {7'b0, post_ovf_a[d], post_data_a[d]}, {7'b0, e});
    end
  endtask

  // Monitor: a result transfer happens on the coming edge when avail and get
  // are both high mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (post_avail_a[0] && post_get_a[0]) pop_and_check(0);
      if (post_avail_a[1] && post_get_a[1]) pop_and_check(1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one term and hold it until accepted; returns at posedge+1 just
  // after the transfer edge, leaving pre_avail high for back-to-back use.
  task automatic send_term(input int d, input logic [7:0] data);
    bit got;
    got = 1'b0;
    pre_avail_a[d] = 1'b1;
    pre_data_a[d]  = data;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = pre_get_a[d];
      step();
    end
    if (!got) check($sformatf("send_timeout_d%0d", d), 16'd0, 16'd1);
  endtask

  task automatic send_series(input int d, input logic [7:0] t0, input logic [7:0] t1,
                             input logic [7:0] t2, input logic [7:0] t3);
    send_term(d, t0);
    send_term(d, t1);
    send_term(d, t2);
    send_term(d, t3);
    pre_avail_a[d] = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 1;
    for (int i = 0; i < 30 && n != 0; i++) begin
      step();
      n = (d == 0) ? exp_q0.size() : exp_q1.size();
    end
    if (n != 0) check($sformatf("drain_timeout_d%0d", d), 16'(n), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] gap_pat;
    logic [7:0] gap_terms [4];
    int         k;

    // Reset state.
    #3;
    check("rst_pre_get",    {14'b0, pre_get_a},    16'h0);
    check("rst_post_avail", {14'b0, post_avail_a}, 16'h0);
    check("rst_post_data0", {8'b0, post_data_a[0]}, 16'h0);
    check("rst_post_data1", {8'b0, post_data_a[1]}, 16'h0);
    check("rst_post_ovf",   {14'b0, post_ovf_a},   16'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check("post_rst_pre_get", {14'b0, pre_get_a}, 16'h3);
    post_get_a = 2'b11;

    // Alternating series: 1.0 - 0.5 + 0.25 - 0.125 = 0.625.
    push_exp(1, 1'b0, 8'h0A);
    send_series(1, 8'h10, 8'h08, 8'h04, 8'h02);
    @(negedge clk);
    check("alt_post_avail_rise", {15'b0, post_avail_a[1]}, 16'h1);
    check("alt_pre_get_low",     {15'b0, pre_get_a[1]},    16'h0);
    step();
    @(negedge clk);
    check("alt_pre_get_back",    {15'b0, pre_get_a[1]},    16'h1);
    check("alt_post_avail_fall", {15'b0, post_avail_a[1]}, 16'h0);
    step();
    wait_drain(1);

    // Saturation, then ovf cleared on the next result.
    push_exp(0, 1'b1, 8'h7F);
    send_series(0, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    wait_drain(0);
    push_exp(0, 1'b0, 8'h04);
    send_series(0, 8'h01, 8'h01, 8'h01, 8'h01);
    wait_drain(0);

    // Cancellation and negative zero.
    push_exp(1, 1'b0, 8'h00);
    send_series(1, 8'h10, 8'h10, 8'h80, 8'h00);
    wait_drain(1);
    push_exp(1, 1'b0, 8'h90);
    send_series(1, 8'h90, 8'h00, 8'h00, 8'h00);
    wait_drain(1);

    // Backpressure: 2.0 - 1.0 + 0 - 0 = 1.0, held for five cycles.
    post_get_a[1] = 1'b0;
    push_exp(1, 1'b0, 8'h10);
    send_series(1, 8'h20, 8'h10, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      pre_avail_a[1] = 1'b1;
      pre_data_a[1]  = 8'h31 + 8'(i);
      @(negedge clk);
      check($sformatf("bp_avail_%0d", i), {15'b0, post_avail_a[1]}, 16'h1);
      check($sformatf("bp_data_%0d", i),  {8'b0, post_data_a[1]},   16'h10);
      check($sformatf("bp_ovf_%0d", i),   {15'b0, post_ovf_a[1]},   16'h0);
      check($sformatf("bp_pre_get_%0d", i), {15'b0, pre_get_a[1]}, 16'h0);
      step();
    end
    pre_avail_a[1] = 1'b0;
    post_get_a[1]  = 1'b1;
    wait_drain(1);
    // Fresh sum: 1 - 2 + 3 - 4 = -2.
    push_exp(1, 1'b0, 8'h82);
    send_series(1, 8'h01, 8'h02, 8'h03, 8'h04);
    wait_drain(1);

    // Upstream gaps: only avail cycles count.
    gap_pat = 7'b1101001;  // bit i = cycle i: 1,0,0,1,0,1,1
    gap_terms[0] = 8'h01;
    gap_terms[1] = 8'h02;
    gap_terms[2] = 8'h03;
    gap_terms[3] = 8'h04;
    k = 0;
    push_exp(0, 1'b0, 8'h0A);
    for (int i = 0; i < 7; i++) begin
      pre_avail_a[0] = gap_pat[i];
      if (gap_pat[i]) begin
        pre_data_a[0] = gap_terms[k];
        k++;
      end else begin
        pre_data_a[0] = 8'h55;
      end
      step();
    end
    pre_avail_a[0] = 1'b0;
    wait_drain(0);

    // Reset mid-operation discards the partial sum.
    send_term(0, 8'h10);
    send_term(0, 8'h08);
    pre_avail_a[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pre_get",    {14'b0, pre_get_a},    16'h0);
    check("midrst_post_avail", {14'b0, post_avail_a}, 16'h0);
    #1 rst_n = 1'b1;
    step();
    push_exp(0, 1'b0, 8'h04);
    send_series(0, 8'h01, 8'h01, 8'h01, 8'h01);
    wait_drain(0);

    check("queue0_empty", 16'(exp_q0.size()), 16'h0);
    check("queue1_empty", 16'(exp_q1.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
